// File: rtl/ysyx_23060236_div.sv
// Restoring 32-bit divider for DIV/DIVU/REM/REMU: magnitudes, one quotient bit per edge, then a sign-fixup edge.
// Result pulses div_outvalid 33 edges after accept; div_ready is low while busy and div_valid is ignored then.
module ysyx_23060236_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_outvalid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  count;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs_abs;
  logic [31:0] dvd_orig;
  logic        sign_q;
  logic        sign_r;
  logic        dvs_zero;

  logic        accept;
  logic        iter_en;
  logic        fix_en;

  logic [31:0] dvd_abs_in;
  logic [31:0] dvs_abs_in;
  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        borrow;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    iter_en   = 1'b0;
    fix_en    = 1'b0;
    case (state)
      IDLE: begin
        if (div_valid) begin
          accept    = 1'b1;
          state_nxt = ITER;
        end
      end
      ITER: begin
        iter_en = 1'b1;
        if (count == 6'd31) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        fix_en    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign div_ready = (state == IDLE);

  // Operand magnitudes: negate only signed operands with bit 31 set.
  always_comb begin
    dvd_abs_in = (div_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
    dvs_abs_in = (div_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;
  end

  // quo initially holds the dividend magnitude; its MSB shifts into rem each step.
  always_comb begin
    rem_sh = {rem, quo[31]};
    borrow = (rem_sh < {1'b0, dvs_abs});
    diff   = rem_sh[31:0] - dvs_abs;
  end

  always_comb begin
    quo_fix = sign_q ? (32'd0 - quo) : quo;
    rem_fix = sign_r ? (32'd0 - rem) : rem;
    if (dvs_zero) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = dvd_orig;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count        <= 6'd0;
      rem          <= 32'd0;
      quo          <= 32'd0;
      dvs_abs      <= 32'd0;
      dvd_orig     <= 32'd0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      dvs_zero     <= 1'b0;
      quotient     <= 32'd0;
      remainder    <= 32'd0;
      div_outvalid <= 1'b0;
    end else begin
      div_outvalid <= fix_en;
      if (accept) begin
        sign_q   <= div_signed & (dividend[31] ^ divisor[31]);
        sign_r   <= div_signed & dividend[31];
        dvs_zero <= (divisor == 32'd0);
        dvd_orig <= dividend;
        dvs_abs  <= dvs_abs_in;
        quo      <= dvd_abs_in;
        rem      <= 32'd0;
        count    <= 6'd0;
      end
      if (iter_en) begin
        rem   <= borrow ? rem_sh[31:0] : diff;
        quo   <= {quo[30:0], ~borrow};
        count <= count + 6'd1;
      end
      if (fix_en) begin
        quotient  <= quo_fix;
        remainder <= rem_fix;
        count     <= 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_div.sv
// Self-checking bench for ysyx_23060236_div: directed RV32M cases, random ops against an arithmetic model, handshake and reset.
module tb_ysyx_23060236_div;

  logic        clock;
  logic        reset;
  logic        div_valid;
  logic        div_ready;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_outvalid;

  int checks = 0;
  int errors = 0;

  ysyx_23060236_div dut (
    .clock        (clock),
    .reset        (reset),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_outvalid (div_outvalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RISC-V semantics straight from the ISA rules.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Call away from a rising edge; returns #1 after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend   = a;
    divisor    = b;
    div_signed = s;
    div_valid  = 1'b1;
    @(posedge clock);
    #1;
    div_valid = 1'b0;
  endtask

  // Counts rising edges after the accept until div_outvalid is seen; ends on a falling edge.
  task automatic wait_done(output logic [31:0] q, output logic [31:0] r,
                           output int lat, output bit timeout);
    lat     = 0;
    timeout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (div_outvalid) begin
        timeout = 1'b0;
        break;
      end
    end
    q = quotient;
    r = remainder;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    div_valid = 1'b0;
    div_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (div_ready !== 1'b1 || div_outvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl ready=%b outvalid=%b want 1/0", div_ready, div_outvalid);
    end
    checks++;
    if (quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_data q=%h r=%h want 0/0", quotient, remainder);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (div_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready=%b want 1", div_ready);
    end
  endtask

  task automatic test_directed;
    logic [31:0] ta [8] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFB,
                            32'd5, 32'h8000_0000, 32'h8000_0000, 32'd7};
    logic [31:0] tb [8] = '{32'd7, 32'd2, 32'd2, 32'd0,
                            32'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE};
    logic        ts [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] eq [8] = '{32'd14, 32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'hFFFF_FFFD};
    logic [31:0] er [8] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFB,
                            32'd5, 32'd0, 32'd0, 32'd1};
    logic [31:0] q, r;
    int          lat;
    bit          to;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      start_op(ta[i], tb[i], ts[i]);
      wait_done(q, r, lat, to);
      checks++;
      if (to || lat != 33) begin
        errors++;
        $display("FAIL dir%0d_latency got=%0d timeout=%0b want 33", i, lat, to);
      end
      checks++;
      if (q !== eq[i] || r !== er[i]) begin
        errors++;
        $display("FAIL dir%0d_result q=%h r=%h want q=%h r=%h", i, q, r, eq[i], er[i]);
      end
      @(negedge clock);
      checks++;
      if (div_outvalid !== 1'b0 || quotient !== eq[i] || remainder !== er[i]) begin
        errors++;
        $display("FAIL dir%0d_pulse_hold outvalid=%b q=%h r=%h want 0 %h %h",
                 i, div_outvalid, quotient, remainder, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, q, r, xq, xr;
    logic        s;
    int          lat;
    bit          to;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 20);
        2: b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      ref_div(a, b, s, xq, xr);
      @(negedge clock);
      start_op(a, b, s);
      wait_done(q, r, lat, to);
      checks++;
      if (to || lat != 33 || q !== xq || r !== xr) begin
        errors++;
        $display("FAIL rand%0d %h/%h s=%b got q=%h r=%h lat=%0d want q=%h r=%h lat=33",
                 i, a, b, s, q, r, lat, xq, xr);
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] q, r;
    int          lat;
    bit          to;
    logic        rdy_seen;
    @(negedge clock);
    start_op(32'd100, 32'd7, 1'b0);
    fork
      begin
        repeat (5) @(negedge clock);
        rdy_seen   = div_ready;
        dividend   = 32'd9;
        divisor    = 32'd4;
        div_signed = 1'b1;
        div_valid  = 1'b1;
        @(negedge clock);
        div_valid = 1'b0;
      end
      wait_done(q, r, lat, to);
    join
    checks++;
    if (rdy_seen !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got=%b want 0", rdy_seen);
    end
    checks++;
    if (to || lat != 33 || q !== 32'd14 || r !== 32'd2) begin
      errors++;
      $display("FAIL busy_ignore q=%h r=%h lat=%0d want 0000000e 00000002 33", q, r, lat);
    end
    @(negedge clock);
    checks++;
    if (div_outvalid !== 1'b0 || div_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_after outvalid=%b ready=%b want 0/1", div_outvalid, div_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q, r;
    int          lat;
    bit          to;
    @(negedge clock);
    start_op(32'd20, 32'd3, 1'b0);
    wait_done(q, r, lat, to);
    checks++;
    if (to || lat != 33 || q !== 32'd6 || r !== 32'd2) begin
      errors++;
      $display("FAIL b2b_first q=%h r=%h lat=%0d want 6 2 33", q, r, lat);
    end
    checks++;
    if (div_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_in_outvalid got=%b want 1", div_ready);
    end
    start_op(32'd9, 32'd4, 1'b0);
    checks++;
    if (div_outvalid !== 1'b0 || div_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept outvalid=%b ready=%b want 0/0", div_outvalid, div_ready);
    end
    wait_done(q, r, lat, to);
    checks++;
    if (to || lat != 33 || q !== 32'd2 || r !== 32'd1) begin
      errors++;
      $display("FAIL b2b_second q=%h r=%h lat=%0d want 2 1 33", q, r, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q, r;
    int          lat;
    bit          to;
    bit          pulse;
    @(negedge clock);
    start_op(32'h1234_5678, 32'd3, 1'b0);
    repeat (9) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (div_outvalid !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || div_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async outvalid=%b q=%h r=%h ready=%b want 0 0 0 1",
               div_outvalid, quotient, remainder, div_ready);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    pulse = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (div_outvalid || !div_ready) pulse = 1'b1;
    end
    checks++;
    if (pulse) begin
      errors++;
      $display("FAIL midreset_no_pulse got=1 want 0");
    end
    start_op(32'd1, 32'd1, 1'b0);
    wait_done(q, r, lat, to);
    checks++;
    if (to || lat != 33 || q !== 32'd1 || r !== 32'd0) begin
      errors++;
      $display("FAIL midreset_after q=%h r=%h lat=%0d want 1 0 33", q, r, lat);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
